// File: rtl/uart_fifo.sv
// uart_fifo: TX and RX byte queues between the CPU I/O bus and the uart block.
// Define UART_FIFO_OVERRUN_EN to always drain uart and flag RX bytes dropped on a full queue.
module uart_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_push,
  input  logic [DATA_BITS-1:0] tx_wdata,
  output logic                 tx_full,
  output logic [DEPTH_LOG2:0]  tx_count,
  input  logic                 rx_pop,
  output logic [DATA_BITS-1:0] rx_rdata,
  output logic                 rx_empty,
  output logic [DEPTH_LOG2:0]  rx_count,
  output logic                 rx_overrun,
  input  logic                 ovr_clr,
  output logic [DATA_BITS-1:0] u_tx_data,
  output logic                 u_wr,
  input  logic                 u_tx_ready,
  input  logic [DATA_BITS-1:0] u_rx_data,
  input  logic                 u_rx_full,
  output logic                 u_rd
);
  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FullCnt = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [DEPTH_LOG2:0]   CntOne  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PtrOne  = DEPTH_LOG2'(1);
  localparam logic StIdle = 1'b0;
  localparam logic StSend = 1'b1;

  // ---------------- TX queue and uart write FSM ----------------
  logic [DATA_BITS-1:0]  tx_mem [Depth];
  logic [DEPTH_LOG2-1:0] tx_wptr, tx_rptr;
  logic                  tx_state;
  logic                  tx_pop, tx_wen;

  assign tx_full = (tx_count == FullCnt);
  assign tx_pop  = (tx_state == StIdle) && u_tx_ready && (tx_count != '0);
  // A pop on the same edge frees a slot, so a push into a full queue is still accepted.
  assign tx_wen  = tx_push && (!tx_full || tx_pop);

  always_ff @(posedge clk) begin
    if (tx_wen) tx_mem[tx_wptr] <= tx_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wptr   <= '0;
      tx_rptr   <= '0;
      tx_count  <= '0;
      tx_state  <= StIdle;
      u_wr      <= 1'b0;
      u_tx_data <= '0;
    end else begin
      if (tx_wen) tx_wptr <= tx_wptr + PtrOne;
      if (tx_pop) tx_rptr <= tx_rptr + PtrOne;
      if (tx_wen && !tx_pop) tx_count <= tx_count + CntOne;
      else if (!tx_wen && tx_pop) tx_count <= tx_count - CntOne;
      // u_wr is registered: uart tx_ready depends on wr combinationally.
      if (tx_state == StIdle) begin
        if (tx_pop) begin
          tx_state  <= StSend;
          u_wr      <= 1'b1;
          u_tx_data <= tx_mem[tx_rptr];
        end
      end else begin
        tx_state <= StIdle;
        u_wr     <= 1'b0;
      end
    end
  end

  // ---------------- RX queue fed from uart ----------------
  logic [DATA_BITS-1:0]  rx_mem [Depth];
  logic [DEPTH_LOG2-1:0] rx_wptr, rx_rptr;
  logic                  rx_qfull, rx_wen, rx_ren;

  assign rx_qfull = (rx_count == FullCnt);
  assign rx_empty = (rx_count == '0);
  assign rx_ren   = rx_pop && !rx_empty;
  assign rx_wen   = u_rx_full && !rx_qfull;
  assign rx_rdata = rx_mem[rx_rptr];

`ifdef UART_FIFO_OVERRUN_EN
  assign u_rd = u_rx_full;

  // A drop and a clear in the same cycle leave the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_overrun <= 1'b0;
    else if (u_rx_full && rx_qfull) rx_overrun <= 1'b1;
    else if (ovr_clr) rx_overrun <= 1'b0;
  end
`else
  logic unused_ovr_clr;

  // Backpressure: uart holds rx_full until there is room.
  assign u_rd           = rx_wen;
  assign rx_overrun     = 1'b0;
  assign unused_ovr_clr = ovr_clr;
`endif

  always_ff @(posedge clk) begin
    if (rx_wen) rx_mem[rx_wptr] <= u_rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_wen) rx_wptr <= rx_wptr + PtrOne;
      if (rx_ren) rx_rptr <= rx_rptr + PtrOne;
      if (rx_wen && !rx_ren) rx_count <= rx_count + CntOne;
      else if (!rx_wen && rx_ren) rx_count <= rx_count - CntOne;
    end
  end

endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed stimulus for uart_fifo, checked every cycle against a queue-based model.
module tb_uart_fifo;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_push = 1'b0;
  logic [7:0] tx_wdata = 8'h00;
  logic       tx_full;
  logic [4:0] tx_count;
  logic       rx_pop = 1'b0;
  logic [7:0] rx_rdata;
  logic       rx_empty;
  logic [4:0] rx_count;
  logic       rx_overrun;
  logic       ovr_clr = 1'b0;
  logic [7:0] u_tx_data;
  logic       u_wr;
  logic       u_tx_ready = 1'b0;
  logic [7:0] u_rx_data = 8'h00;
  logic       u_rx_full = 1'b0;
  logic       u_rd;

  uart_fifo #(.DATA_BITS(8), .DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst),
    .tx_push(tx_push), .tx_wdata(tx_wdata), .tx_full(tx_full), .tx_count(tx_count),
    .rx_pop(rx_pop), .rx_rdata(rx_rdata), .rx_empty(rx_empty), .rx_count(rx_count),
    .rx_overrun(rx_overrun), .ovr_clr(ovr_clr),
    .u_tx_data(u_tx_data), .u_wr(u_wr), .u_tx_ready(u_tx_ready),
    .u_rx_data(u_rx_data), .u_rx_full(u_rx_full), .u_rd(u_rd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  byte unsigned m_txq[$];
  byte unsigned m_rxq[$];
  logic         m_wr = 1'b0;
  logic [7:0]   m_tx_data = 8'h00;
  logic         m_ovr = 1'b0;
  bit           pop_tx, push_ok, fill, drop;
  int           pre_rx;

  function automatic logic exp_rd();
`ifdef UART_FIFO_OVERRUN_EN
    return u_rx_full;
`else
    return u_rx_full && (m_rxq.size() < DEPTH);
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_txq.delete();
      m_rxq.delete();
      m_wr      = 1'b0;
      m_tx_data = 8'h00;
      m_ovr     = 1'b0;
    end else begin
      // A byte leaves only when uart is ready and no write pulse is in progress.
      pop_tx  = !m_wr && u_tx_ready && (m_txq.size() > 0);
      push_ok = tx_push && ((m_txq.size() < DEPTH) || pop_tx);
      if (pop_tx) begin
        m_tx_data = m_txq.pop_front();
        m_wr      = 1'b1;
      end else begin
        m_wr = 1'b0;
      end
      if (push_ok) m_txq.push_back(tx_wdata);

      pre_rx = m_rxq.size();
      fill   = u_rx_full && (pre_rx < DEPTH);
      drop   = u_rx_full && (pre_rx == DEPTH);
      if (rx_pop && pre_rx > 0) void'(m_rxq.pop_front());
      if (fill) m_rxq.push_back(u_rx_data);
`ifdef UART_FIFO_OVERRUN_EN
      if (drop) m_ovr = 1'b1;
      else if (ovr_clr) m_ovr = 1'b0;
`endif
    end
  end

  byte unsigned tx_seen[$];
  int           rd_cycles = 0;

  always @(negedge clk) begin
    check("u_wr", u_wr, m_wr);
    check("u_tx_data", u_tx_data, m_tx_data);
    check("tx_count", tx_count, m_txq.size());
    check("tx_full", tx_full, m_txq.size() == DEPTH);
    check("rx_count", rx_count, m_rxq.size());
    check("rx_empty", rx_empty, m_rxq.size() == 0);
    if (m_rxq.size() > 0) check("rx_rdata", rx_rdata, m_rxq[0]);
    check("u_rd", u_rd, exp_rd());
    check("rx_overrun", rx_overrun, m_ovr);
    if (u_wr) tx_seen.push_back(u_tx_data);
    if (u_rd) rd_cycles++;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_push  = 1'b1;
    tx_wdata = b;
    step();
    tx_push = 1'b0;
  endtask

  task automatic pop_rx();
    rx_pop = 1'b1;
    step();
    rx_pop = 1'b0;
  endtask

  // uart receiver: hold rx_full until u_rd is seen, then clear after that edge.
  task automatic send_rx(input logic [7:0] b);
    bit got;
    got       = 1'b0;
    u_rx_full = 1'b1;
    u_rx_data = b;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (u_rd) begin
        got = 1'b1;
        break;
      end
      step();
    end
    check("send_rx_handshake", got, 1'b1);
    step();
    u_rx_full = 1'b0;
  endtask

  initial begin
    repeat (2) step();
    check("reset_tx_count", tx_count, 0);
    check("reset_rx_empty", rx_empty, 1);
    check("reset_u_wr", u_wr, 0);
    check("reset_u_tx_data", u_tx_data, 8'h00);
    rst = 1'b0;
    step();

    // TX: three bytes, one ready window each
    tx_seen.delete();
    push_tx(8'h41);
    push_tx(8'h42);
    push_tx(8'h43);
    check("tx3_count", tx_count, 3);
    repeat (3) step();
    for (int k = 0; k < 3; k++) begin
      u_tx_ready = 1'b1;
      step();
      u_tx_ready = 1'b0;
      repeat (3) step();
    end
    check("tx3_pulses", tx_seen.size(), 3);
    if (tx_seen.size() == 3) begin
      check("tx3_byte0", tx_seen[0], 8'h41);
      check("tx3_byte1", tx_seen[1], 8'h42);
      check("tx3_byte2", tx_seen[2], 8'h43);
    end
    check("tx3_drained", tx_count, 0);

    // TX: overfill, push during drain while full, then drain everything
    tx_seen.delete();
    for (int i = 0; i < 17; i++) push_tx(8'(i));
    check("txfull_flag", tx_full, 1);
    check("txfull_count", tx_count, 16);
    u_tx_ready = 1'b1;
    tx_push    = 1'b1;
    tx_wdata   = 8'h11;
    step();
    tx_push = 1'b0;
    check("txfull_push_pop", tx_count, 16);
    repeat (40) step();
    u_tx_ready = 1'b0;
    check("txfull_pulses", tx_seen.size(), 17);
    if (tx_seen.size() == 17) begin
      for (int i = 0; i < 16; i++) check("txfull_order", tx_seen[i], 8'(i));
      check("txfull_last", tx_seen[16], 8'h11);
    end
    check("txfull_drained", tx_count, 0);

    // RX: two bytes, each drained by exactly one u_rd cycle
    rd_cycles = 0;
    send_rx(8'h55);
    send_rx(8'hAA);
    check("rx2_rd_cycles", rd_cycles, 2);
    check("rx2_head0", rx_rdata, 8'h55);
    pop_rx();
    check("rx2_head1", rx_rdata, 8'hAA);
    pop_rx();
    check("rx2_empty", rx_empty, 1);

    // RX: a new byte completes on the same edge as u_rd
    rd_cycles = 0;
    u_rx_full = 1'b1;
    u_rx_data = 8'h77;
    #1;
    check("same_edge_rd0", u_rd, 1);
    step();
    u_rx_data = 8'h99;
    #1;
    check("same_edge_rd1", u_rd, 1);
    step();
    u_rx_full = 1'b0;
    check("same_edge_count", rx_count, 2);
    check("same_edge_rd_cycles", rd_cycles, 2);
    check("same_edge_head0", rx_rdata, 8'h77);
    pop_rx();
    check("same_edge_head1", rx_rdata, 8'h99);
    pop_rx();

    // RX: fill to 16, then one more byte
    for (int i = 0; i < 16; i++) send_rx(8'(i));
    check("rxfull_count", rx_count, 16);
    check("rxfull_head", rx_rdata, 8'h00);
    u_rx_full = 1'b1;
    u_rx_data = 8'hEE;
    #1;
`ifdef UART_FIFO_OVERRUN_EN
    check("ovr_rd", u_rd, 1);
    step();
    u_rx_full = 1'b0;
    check("ovr_set", rx_overrun, 1);
    check("ovr_count", rx_count, 16);
    step();
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("ovr_clear", rx_overrun, 0);
    u_rx_full = 1'b1;
    ovr_clr   = 1'b1;
    step();
    u_rx_full = 1'b0;
    ovr_clr   = 1'b0;
    check("ovr_set_wins", rx_overrun, 1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
`else
    check("bp_rd", u_rd, 0);
    repeat (3) step();
    check("bp_count", rx_count, 16);
    check("bp_no_ovr", rx_overrun, 0);
    pop_rx();
    step();
    u_rx_full = 1'b0;
    check("bp_refill", rx_count, 16);
`endif
    rx_pop = 1'b1;
    repeat (18) step();
    rx_pop = 1'b0;
    check("rx_drained", rx_empty, 1);

    // Reset mid-transfer
    send_rx(8'hA1);
    send_rx(8'hA2);
    send_rx(8'hA3);
    for (int i = 0; i < 6; i++) push_tx(8'h60 + 8'(i));
    u_tx_ready = 1'b1;
    step();
    u_tx_ready = 1'b0;
    check("pre_rst_u_wr", u_wr, 1);
    check("pre_rst_tx_count", tx_count, 5);
    check("pre_rst_rx_count", rx_count, 3);
    #1;
    rst = 1'b1;
    #1;
    check("rst_u_wr", u_wr, 0);
    check("rst_tx_count", tx_count, 0);
    check("rst_rx_count", rx_count, 0);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_tx_full", tx_full, 0);
    step();
    rst = 1'b0;
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule

// File: doc/uart_fifo.md
Name: uart_fifo

Overview:
Buffering stage between the CPU I/O bus and the uart block. It holds a TX queue that feeds uart's tx_data/wr/tx_ready handshake, and an RX queue that drains uart's rx_data/rx_full/rd handshake. Software can burst bytes without polling per character, and received bytes survive until popped.

Parameters:
DATA_BITS, 8, byte width; must match uart DATA_BITS
DEPTH_LOG2, 4, log2 of the entry count of each queue (default 16 entries)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
tx_push  in  1  enqueue tx_wdata into the TX queue
tx_wdata  in  DATA_BITS  byte to transmit
tx_full  out  1  TX queue holds 2^DEPTH_LOG2 entries
tx_count  out  DEPTH_LOG2+1  TX queue occupancy
rx_pop  in  1  dequeue the RX head
rx_rdata  out  DATA_BITS  RX head (show-ahead); valid while !rx_empty
rx_empty  out  1  RX queue holds 0 entries
rx_count  out  DEPTH_LOG2+1  RX queue occupancy
rx_overrun  out  1  sticky drop flag (see Optional Feature)
ovr_clr  in  1  clears rx_overrun
u_tx_data  out  DATA_BITS  to uart tx_data
u_wr  out  1  to uart wr
u_tx_ready  in  1  from uart tx_ready
u_rx_data  in  DATA_BITS  from uart rx_data
u_rx_full  in  1  from uart rx_full
u_rd  out  1  to uart rd

Behaviour:
- Reset: all pointers and counts = 0; tx_full=0; rx_empty=1; u_wr=0; u_tx_data=0; rx_overrun=0; TX FSM = IDLE. Queue contents are not reset.
- Each queue is a circular buffer with DEPTH_LOG2-bit read and write pointers. Pointers wrap modulo 2^DEPTH_LOG2. The count register is DEPTH_LOG2+1 bits, so full = count==2^DEPTH_LOG2.
- tx_push while tx_full: the byte is dropped and state does not change. tx_push together with a same-cycle TX drain while full: the push is accepted, the pop frees a slot, and the count does not change.
- rx_pop while rx_empty: ignored. rx_pop together with a same-cycle RX fill: both take effect and the count does not change.
- TX FSM, registered:
  - IDLE -> SEND when u_tx_ready=1 and the TX queue is non-empty. At that edge: u_tx_data <= head, TX read pointer advances, u_wr <= 1.
  - SEND -> IDLE unconditionally; u_wr <= 0. u_wr is therefore exactly a 1-cycle pulse.
  - u_wr is never driven combinationally, because uart tx_ready depends on wr. u_tx_data holds its value until the next SEND.
  - Back-to-back bytes: the next SEND waits until uart returns tx_ready (after its stop bit).
- RX drain, combinational:
  - u_rd = u_rx_full & !rx_queue_full. This term is extended by the Optional Feature.
  - In the cycle u_rd=1, u_rx_data is written at the write pointer on the same edge at which uart clears rx_full.
  - If uart completes a new byte on that same edge, uart keeps rx_full=1 with the new data, and that byte is captured on a following cycle. No byte is lost.
- Latency:
  - tx_push to u_wr high: 2 cycles minimum (the queue write edge, then the IDLE->SEND edge).
  - u_rx_full rising to !rx_empty: 1 edge.
- Reset mid-transfer:
  - Asynchronously clears u_wr and empties both queues.
  - A byte already handed to uart completes on the line under uart's own reset.

Optional Feature:
Macro UART_FIFO_OVERRUN_EN.
- Defined:
  - u_rd = u_rx_full, regardless of RX queue state.
  - When the RX queue is full, the byte is discarded and rx_overrun <= 1. The flag stays set until ovr_clr=1.
  - If ovr_clr and a drop occur in the same cycle, the set wins.
- Not defined:
  - RX backpressures: uart keeps rx_full=1 and its own next reception overwrites rx_data.
  - rx_overrun is constant 0 and ovr_clr is ignored.

Test Plan:
- Reset, then push 0x41,0x42,0x43 with u_tx_ready held 1 for one cycle after each u_wr -> three single-cycle u_wr pulses, u_tx_data 0x41,0x42,0x43 in order, tx_count 3->0, no pulse while u_tx_ready=0.
- Push 17 bytes with u_tx_ready=0 (DEPTH_LOG2=4) -> tx_full=1 after 16, byte 17 dropped, tx_count=16; release ready -> 16 bytes drain with 0x00..0x0F ordering preserved.
- Pulse u_rx_full with data 0x55 then 0xAA, uart model clears on u_rd -> u_rd high exactly one cycle each, rx_rdata=0x55, pop -> 0xAA, pop -> rx_empty=1.
- New uart byte completes on the same edge as u_rd (model keeps rx_full=1, data 0x99) -> 0x99 captured next cycle, rx_count increments twice total.
- Fill RX to 16 then present one more byte: without macro, u_rd=0 and rx_count=16; with UART_FIFO_OVERRUN_EN, u_rd=1, byte dropped, rx_overrun=1; ovr_clr -> 0.
- Assert rst while TX holds 5 and RX holds 3 entries with u_wr high -> next cycle u_wr=0, tx_count=0, rx_count=0, rx_empty=1, tx_full=0.
